muldiv_sched: RTL and testbench
===============================

Name: muldiv_sched

Overview:
- Execute-stage sequencer for the HI/LO mul/div resource.
- Accepts a mult/multu/div/divu issued in E and runs a fixed-latency multiply or a radix-2 restoring divide over several cycles.
- Holds the pipeline with stallE until the result is ready, then presents the 32-bit HI and LO results for one cycle so the instruction advances to M with mdToHilo data.
- Cancels cleanly on flushE.

Parameters:
- MUL_LAT, 2: cycles spent in MUL state (range 1..7).
- DIV_ITERS, 32: restoring-divide iterations (one quotient bit per cycle); fixed to the operand width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- startE  in  1  valid mul/div instruction present in E (mdToHiloE and not a hilo move)
- mulOrdivE  in  1  0 = multiply, 1 = divide
- mdIsSignE  in  1  1 = signed (mult/div), 0 = unsigned
- srcaE  in  32  rs operand (multiplicand / dividend)
- srcbE  in  32  rt operand (multiplier / divisor)
- flushE  in  1  cancel the in-flight operation
- stallE  out  1  hold F/D/E; combinational
- busyE  out  1  state is MUL or DIV
- doneE  out  1  result valid this cycle; one-cycle pulse
- hiE  out  32  HI result (product[63:32] or remainder)
- loE  out  32  LO result (product[31:0] or quotient)

Behaviour:
- States: IDLE, MUL, DIV, DONE. On rst: state = IDLE, counter = 0, hiE = loE = 0, doneE = 0. rst is asynchronous and may assert mid-operation; the operation is lost.
- IDLE with startE = 1 and flushE = 0:
  - Latch operands and sign mode.
  - Go to MUL with counter = MUL_LAT-1, or to DIV with counter = DIV_ITERS-1.
- stallE = startE & (state != DONE) & ~flushE. It is therefore high in the issue cycle and every MUL/DIV cycle, and low in DONE, so the instruction leaves E exactly in the DONE cycle.
- MUL:
  - Compute the 64-bit product of the latched operands (signed or unsigned per mdIsSignE).
  - Decrement counter; at 0 register {hiE, loE} = product and go to DONE.
  - Total stall = MUL_LAT+1 cycles.
- DIV:
  - Operate on magnitudes (signed mode: two's-complement absolute value; 0x80000000 maps to magnitude 2^31).
  - Each cycle: shift remainder/quotient left by 1; subtract divisor if remainder ≥ divisor and set the quotient bit.
  - After DIV_ITERS cycles apply signs:
    - quotient negated if the operand signs differ;
    - remainder takes the dividend's sign.
  - Register hiE = remainder, loE = quotient, go to DONE. Total stall = 33 cycles.
- Divide by zero: still runs the full 32 iterations; result forced to loE = 0xFFFFFFFF, hiE = srcaE (as latched), independent of sign mode.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: loE = 0x80000000, hiE = 0.
- DONE: doneE = 1 for exactly this cycle; hiE/loE valid. startE is ignored (same instruction). Next state is IDLE.
- hiE/loE hold their last value in all other states; they are not cleared on completion.
- flushE:
  - In MUL or DIV: next state IDLE, doneE stays 0, hiE/loE unchanged.
  - In IDLE together with startE: no start.
  - In DONE: doneE still pulses (the instruction already left E); the flush applies to the new E occupant.
- Back-to-back ops: a new startE in the IDLE cycle after DONE starts immediately. There is no idle bubble beyond that cycle.
- Operands must not be sampled after the issue cycle; srcaE/srcbE may change (forwarding) while the block is busy.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: in the first DIV cycle, if divisor ≠ 0 and |dividend| < |divisor|, skip the iterations. Result is loE = 0, hiE = dividend (original signed value); go to DONE after that one DIV cycle, giving a total stall of 2 cycles. All other divides are unchanged.
- Undefined: every divide takes DIV_ITERS cycles; no magnitude comparator is synthesised.

Test Plan:
- mult: srcaE = 0xFFFFFFFE (-2), srcbE = 3, signed, MUL_LAT = 2 -> stallE high 3 cycles, then doneE with hiE = 0xFFFFFFFF, loE = 0xFFFFFFFA.
- divu: 100 / 7 -> stallE high 33 cycles, doneE with loE = 14, hiE = 2.
- div: -7 / 2 signed -> loE = 0xFFFFFFFD (-3), hiE = 0xFFFFFFFF (-1).
- div by zero: srcaE = 0x12345678, srcbE = 0 -> after 33 stall cycles loE = 0xFFFFFFFF, hiE = 0x12345678.
- flushE at DIV cycle 10 -> state IDLE next cycle, stallE low, no doneE, hiE/loE keep the prior result. A new divu issued the following cycle completes normally.
- rst pulsed asynchronously mid-MUL -> hiE = loE = 0, doneE = 0, stallE = 0 immediately. With MULDIV_EARLY_OUT_EN: 3 / 10 -> stall 2 cycles, loE = 0, hiE = 3.

Source files
------------

// File: rtl/muldiv_sched_if.sv
// rtl/muldiv_sched_if.sv - E-stage handshake bundle for the HI/LO mul/div sequencer
//
// Purpose: groups the E-stage request, flush, stall and result signals of muldiv_sched.
// Signals:
//   startE, mulOrdivE, mdIsSignE, srcaE[31:0], srcbE[31:0], flushE : pipeline -> sequencer
//   stallE, busyE, doneE, hiE[31:0], loE[31:0]                     : sequencer -> pipeline
// Modports: master (pipeline side), slave (sequencer side).
interface muldiv_sched_if;
   logic        startE;
   logic        mulOrdivE;
   logic        mdIsSignE;
   logic [31:0] srcaE;
   logic [31:0] srcbE;
   logic        flushE;
   logic        stallE;
   logic        busyE;
   logic        doneE;
   logic [31:0] hiE;
   logic [31:0] loE;

   modport master (
      output startE, mulOrdivE, mdIsSignE, srcaE, srcbE, flushE,
      input  stallE, busyE, doneE, hiE, loE
   );

   modport slave (
      input  startE, mulOrdivE, mdIsSignE, srcaE, srcbE, flushE,
      output stallE, busyE, doneE, hiE, loE
   );
endinterface

// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - E-stage sequencer for the HI/LO multiply/divide resource
//
// Purpose: accepts mult/multu/div/divu in E, runs a fixed-latency multiply or a
// radix-2 restoring divide, stalls E until done and presents HI/LO for one cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   md   : muldiv_sched_if.slave (startE, mulOrdivE, mdIsSignE, srcaE, srcbE,
//          flushE in; stallE, busyE, doneE, hiE, loE out)
// Parameters: MUL_LAT (cycles in MUL, 1..7), DIV_ITERS (divide iterations, 32).
// Optional feature macro: MULDIV_EARLY_OUT_EN (divide early-out when |dividend| < |divisor|).
module muldiv_sched #(
   parameter int MUL_LAT   = 2,
   parameter int DIV_ITERS = 32
) (
   input  logic          clk,
   input  logic          rst,
   muldiv_sched_if.slave md
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t      state_q;
   logic [5:0]  cnt_q;
   logic [31:0] a_q, b_q;      // operands exactly as issued
   logic        sign_q;
   logic [31:0] rem_q;         // partial remainder
   logic [31:0] quo_q;         // dividend magnitude shifting out, quotient shifting in
   logic [31:0] dvs_q;         // divisor magnitude
   logic [31:0] hi_q, lo_q;
   logic        done_q;

   // Two's-complement magnitude; 0x80000000 yields 2^31 as an unsigned value.
   function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
      return (s && x[31]) ? 32'(-x) : x;
   endfunction

   // Multiply datapath: full 64-bit product of the latched operands.
   logic [63:0] a_ext, b_ext, prod_d;
   always_comb begin
      a_ext  = sign_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
      b_ext  = sign_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
      prod_d = a_ext * b_ext;
   end

   // Restoring-divide step plus final sign fix-up, used on the last iteration.
   logic [32:0] rem_sh;
   logic        rem_ge;
   logic [31:0] rem_d, quo_d, hi_div_d, lo_div_d;
   always_comb begin
      rem_sh = {rem_q, quo_q[31]};
      rem_ge = rem_sh >= {1'b0, dvs_q};
      // The remainder is always below the divisor (<= 2^31), so 32 bits suffice.
      rem_d  = rem_ge ? (rem_sh[31:0] - dvs_q) : rem_sh[31:0];
      quo_d  = {quo_q[30:0], rem_ge};
      if (b_q == 32'd0) begin
         hi_div_d = a_q;
         lo_div_d = 32'hFFFF_FFFF;
      end else begin
         hi_div_d = (sign_q && a_q[31])           ? 32'(-rem_d) : rem_d;
         lo_div_d = (sign_q && (a_q[31] ^ b_q[31])) ? 32'(-quo_d) : quo_d;
      end
   end

`ifdef MULDIV_EARLY_OUT_EN
   // quo_q still holds |dividend| in the first DIV cycle.
   logic early_d;
   assign early_d = (cnt_q == 6'(DIV_ITERS - 1)) && (dvs_q != 32'd0) && (quo_q < dvs_q);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sign_q  <= 1'b0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (md.startE && !md.flushE) begin
                  a_q    <= md.srcaE;
                  b_q    <= md.srcbE;
                  sign_q <= md.mdIsSignE;
                  rem_q  <= '0;
                  quo_q  <= mag(md.srcaE, md.mdIsSignE);
                  dvs_q  <= mag(md.srcbE, md.mdIsSignE);
                  if (md.mulOrdivE) begin
                     state_q <= S_DIV;
                     cnt_q   <= 6'(DIV_ITERS - 1);
                  end else begin
                     state_q <= S_MUL;
                     cnt_q   <= 6'(MUL_LAT - 1);
                  end
               end
            end
            S_MUL: begin
               if (md.flushE) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == 6'd0) begin
                  {hi_q, lo_q} <= prod_d;
                  done_q       <= 1'b1;
                  state_q      <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 6'd1;
               end
            end
            S_DIV: begin
               if (md.flushE) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
`ifdef MULDIV_EARLY_OUT_EN
               end else if (early_d) begin
                  hi_q    <= a_q;
                  lo_q    <= '0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                  cnt_q   <= '0;
`endif
               end else if (cnt_q == 6'd0) begin
                  hi_q    <= hi_div_d;
                  lo_q    <= lo_div_d;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
                  cnt_q <= cnt_q - 6'd1;
               end
            end
            S_DONE: begin
               // startE here still belongs to the completing instruction.
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign md.stallE = md.startE && (state_q != S_DONE) && !md.flushE;
   assign md.busyE  = (state_q == S_MUL) || (state_q == S_DIV);
   assign md.doneE  = done_q;
   assign md.hiE    = hi_q;
   assign md.loE    = lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - self-checking bench for muldiv_sched
module tb_muldiv_sched;
   localparam int MUL_LAT   = 2;
   localparam int DIV_ITERS = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   muldiv_sched_if md ();
   muldiv_sched #(.MUL_LAT(MUL_LAT), .DIV_ITERS(DIV_ITERS)) dut (.clk(clk), .rst(rst), .md(md));

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit          is_div;
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic longint magn(input logic [31:0] x, input bit s);
      longint v;
      v = s ? longint'($signed(x)) : longint'({32'd0, x});
      return (v < 0) ? -v : v;
   endfunction

   function automatic int ref_stall(input bit is_div, input bit sgn, input logic [31:0] a, input logic [31:0] b);
      if (!is_div) return MUL_LAT + 1;
`ifdef MULDIV_EARLY_OUT_EN
      if (b != 32'd0 && magn(a, sgn) < magn(b, sgn)) return 2;
`endif
      return DIV_ITERS + 1;
   endfunction

   task automatic ref_calc(input bit is_div, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo);
      longint sa, sb, p, q, r;
      sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      if (!is_div) begin
         p  = sa * sb;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'd0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         hi = r[31:0];
         lo = q[31:0];
      end
   endtask

   // Issues one op at the next falling edge and leaves the bench in the DONE cycle.
   task automatic run_op(input string tag, input bit is_div, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      int stalls;
      bit seen;
      @(negedge clk);
      md.startE = 1'b1; md.mulOrdivE = is_div; md.mdIsSignE = sgn;
      md.srcaE = a; md.srcbE = b; md.flushE = 1'b0;
      #1;
      stalls = 0;
      seen   = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (md.doneE) begin
            seen = 1'b1;
            break;
         end
         if (md.stallE) stalls++;
         @(negedge clk);
         md.srcaE = $urandom;
         md.srcbE = $urandom;
         #1;
      end
      chk({tag, "_done"}, 64'(seen), 64'd1);
      chk({tag, "_stall"}, 64'(stalls), 64'(ref_stall(is_div, sgn, a, b)));
      chk({tag, "_hi"}, 64'(md.hiE), 64'(eh));
      chk({tag, "_lo"}, 64'(md.loE), 64'(el));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] eh, el, ra, rb;
      bit rd, rs;

      vecs[0] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vecs[1] = '{1'b1, 1'b0, 32'd100,       32'd7,         32'd2,         32'd14};
      vecs[2] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{1'b1, 1'b0, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
      vecs[4] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
      vecs[5] = '{1'b1, 1'b1, 32'd3,         32'd10,        32'd3,         32'd0};
      vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[7] = '{1'b1, 1'b1, 32'h8765_4321, 32'd0,         32'h8765_4321, 32'hFFFF_FFFF};

      rst = 1'b1;
      md.startE = 1'b0; md.mulOrdivE = 1'b0; md.mdIsSignE = 1'b0;
      md.srcaE = '0; md.srcbE = '0; md.flushE = 1'b0;
      @(negedge clk); #1;
      chk("rst_hi", 64'(md.hiE), 64'd0);
      chk("rst_lo", 64'(md.loE), 64'd0);
      chk("rst_done", 64'(md.doneE), 64'd0);
      chk("rst_busy", 64'(md.busyE), 64'd0);
      chk("rst_stall", 64'(md.stallE), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].is_div, vecs[i].sgn, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo);
         @(negedge clk);
         md.startE = 1'b0;
         #1;
         chk($sformatf("vec%0d_pulse", i), 64'(md.doneE), 64'd0);
      end

      // Flush in IDLE together with start: nothing starts.
      @(negedge clk);
      md.startE = 1'b1; md.mulOrdivE = 1'b1; md.flushE = 1'b1;
      #1;
      chk("idleflush_stall", 64'(md.stallE), 64'd0);
      @(negedge clk);
      md.startE = 1'b0; md.flushE = 1'b0;
      #1;
      chk("idleflush_busy", 64'(md.busyE), 64'd0);

      // Flush in DIV cycle 10: result registers keep the prior result.
      run_op("preflush", 1'b0, 1'b0, 32'd5, 32'd6, 32'd0, 32'd30);
      @(negedge clk);
      md.startE = 1'b1; md.mulOrdivE = 1'b1; md.mdIsSignE = 1'b0;
      md.srcaE = 32'd1000; md.srcbE = 32'd3;
      repeat (10) begin
         @(negedge clk);
         md.srcaE = $urandom; md.srcbE = $urandom;
      end
      #1;
      chk("flush_busy_before", 64'(md.busyE), 64'd1);
      md.flushE = 1'b1;
      #1;
      chk("flush_stall", 64'(md.stallE), 64'd0);
      @(negedge clk);
      md.flushE = 1'b0; md.startE = 1'b0;
      #1;
      chk("flush_busy_after", 64'(md.busyE), 64'd0);
      chk("flush_stall_after", 64'(md.stallE), 64'd0);
      chk("flush_done", 64'(md.doneE), 64'd0);
      chk("flush_hi_hold", 64'(md.hiE), 64'd0);
      chk("flush_lo_hold", 64'(md.loE), 64'd30);
      run_op("postflush", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);

      // Asynchronous reset in the middle of MUL.
      @(negedge clk);
      md.startE = 1'b1; md.mulOrdivE = 1'b0; md.mdIsSignE = 1'b1;
      md.srcaE = 32'd7; md.srcbE = 32'd9;
      @(negedge clk); #1;
      chk("mrst_busy", 64'(md.busyE), 64'd1);
      #2;
      md.startE = 1'b0;
      rst = 1'b1;
      #1;
      chk("mrst_hi", 64'(md.hiE), 64'd0);
      chk("mrst_lo", 64'(md.loE), 64'd0);
      chk("mrst_done", 64'(md.doneE), 64'd0);
      chk("mrst_stall", 64'(md.stallE), 64'd0);
      chk("mrst_busy_off", 64'(md.busyE), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("postrst", 1'b0, 1'b1, 32'd7, 32'd9, 32'd0, 32'd63);

      // Random back-to-back ops against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         rd = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         ra = pick();
         rb = pick();
         ref_calc(rd, rs, ra, rb, eh, el);
         run_op($sformatf("rnd%0d", i), rd, rs, ra, rb, eh, el);
      end
      @(negedge clk);
      md.startE = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
